// File: rtl/tart_vis_pkg.sv
// tart_vis_pkg: shared constants and FSM state type for the visibilities frame path.
package tart_vis_pkg;
  localparam int ACCUM_DEF = 36;
  localparam int CORES = 6;
  localparam int LOOP0 = 3;
  localparam int LOOP1 = 15;
  localparam int WORDS_DEF = CORES * LOOP0 * LOOP1;
  typedef enum logic [1:0] {FILL, DISCARD, STALL} state_t;
endpackage

// File: rtl/vis_bank_ram.sv
// vis_bank_ram: simple dual-port RAM with registered, resettable read data.
module vis_bank_ram #(
  parameter int W = 72,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/vis_frame_reader.sv
// vis_frame_reader: validates visibility frames from the correlator stream and
// stores them in a ping-pong buffer read back by the host.
module vis_frame_reader
  import tart_vis_pkg::*;
#(
  parameter int ACCUM = ACCUM_DEF,
  parameter int WORDS = WORDS_DEF,
  localparam int ADDR = $clog2(WORDS)
) (
  input  logic             bus_clock,
  input  logic             reset,
  input  logic [ACCUM-1:0] s_revis_i,
  input  logic [ACCUM-1:0] s_imvis_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_last_i,
  output logic             frame_valid_o,
  output logic [15:0]      frame_num_o,
  input  logic             rd_en_i,
  input  logic [ADDR-1:0]  rd_addr_i,
  output logic [ACCUM-1:0] rd_revis_o,
  output logic [ACCUM-1:0] rd_imvis_o,
  output logic             rd_valid_o,
  input  logic             rd_done_i,
  output logic             err_o,
  output logic [7:0]       err_count_o
);
  state_t state, state_n;
  logic [1:0] full, full_n;
  logic wr_bank, wr_bank_n, rd_bank, rd_bank_n;
  logic [ADDR-1:0] wr_idx, wr_idx_n;
  logic hs, rel, at_end, good, bad;
  logic [2*ACCUM-1:0] rdata;
  assign frame_valid_o = full[rd_bank];
  assign {rd_revis_o, rd_imvis_o} = rdata;
  always_comb begin
    hs = s_valid_i && s_ready_o;
    rel = rd_done_i && full[rd_bank];
    at_end = wr_idx == ADDR'(WORDS - 1);
    state_n = state;
    wr_idx_n = wr_idx;
    wr_bank_n = wr_bank;
    rd_bank_n = rd_bank ^ rel;
    good = 1'b0;
    bad = 1'b0;
    full_n = full;
    if (rel) full_n[rd_bank] = 1'b0;
    case (state)
      FILL:
        if (hs) begin
          wr_idx_n = wr_idx + 1'b1;
          if (s_last_i && at_end) begin
            good = 1'b1;
            full_n[wr_bank] = 1'b1;
            wr_bank_n = ~wr_bank;
            wr_idx_n = '0;
            // a release in this same cycle already cleared the other bank
            if (full_n[~wr_bank]) state_n = STALL;
          end else if (s_last_i || at_end) begin
            bad = 1'b1;
            wr_idx_n = '0;
            state_n = s_last_i ? FILL : DISCARD;
          end
        end
      DISCARD:
        if (hs && s_last_i) begin
          state_n = FILL;
          wr_idx_n = '0;
        end
      STALL: state_n = rel ? FILL : STALL;
      default: state_n = FILL;
    endcase
  end
  always_ff @(posedge bus_clock or posedge reset)
    if (reset) begin
      state <= FILL;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
      s_ready_o <= 1'b0;
      frame_num_o <= '0;
      err_o <= 1'b0;
      err_count_o <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      state <= state_n;
      full <= full_n;
      wr_bank <= wr_bank_n;
      rd_bank <= rd_bank_n;
      wr_idx <= wr_idx_n;
      s_ready_o <= state_n != STALL;
      frame_num_o <= frame_num_o + 16'(good);
      err_o <= bad;
      if (bad && err_count_o != 8'hff) err_count_o <= err_count_o + 8'd1;
      rd_valid_o <= rd_en_i;
    end
  vis_bank_ram #(.W(2 * ACCUM), .AW(ADDR + 1)) u_ram (
    .clk(bus_clock),
    .rst(reset),
    .we(hs && state == FILL),
    .waddr({wr_bank, wr_idx}),
    .wdata({s_revis_i, s_imvis_i}),
    .re(rd_en_i),
    .raddr({rd_bank, rd_addr_i}),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_vis_frame_reader.sv
// tb_vis_frame_reader: directed scenarios for the frame reader with a 4-word frame.
module tb_vis_frame_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [35:0] s_revis = '0, s_imvis = '0;
  logic s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic frame_valid;
  logic [15:0] frame_num;
  logic rd_en = 1'b0, rd_done = 1'b0, rd_valid;
  logic [1:0] rd_addr = '0;
  logic [35:0] rd_re, rd_im;
  logic err;
  logic [7:0] err_count;
  int compared = 0;
  int mismatched = 0;

  vis_frame_reader #(.ACCUM(36), .WORDS(4)) dut (
    .bus_clock(clk), .reset(rst),
    .s_revis_i(s_revis), .s_imvis_i(s_imvis), .s_valid_i(s_valid),
    .s_ready_o(s_ready), .s_last_i(s_last),
    .frame_valid_o(frame_valid), .frame_num_o(frame_num),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_revis_o(rd_re), .rd_imvis_o(rd_im),
    .rd_valid_o(rd_valid), .rd_done_i(rd_done),
    .err_o(err), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0; rd_done = 1'b0; rd_addr = '0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic send_frame(input int n, input int base, input int last_at);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_revis = 36'(base + i);
      s_imvis = -36'(base + i);
      s_last = (i == last_at - 1);
      for (int t = 0; t < 50 && !s_ready; t++) cycle();
      if (!s_ready) begin
        compared++; mismatched++;
        $display("FAIL beat_timeout ready=%0b required=1", s_ready);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      cycle();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    compared++;
    if ({s_ready, frame_valid, frame_num, rd_valid, rd_re, rd_im, err, err_count} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs ready=%0b fv=%0b num=%0d rv=%0b err=%0b cnt=%0d required all 0",
               s_ready, frame_valid, frame_num, rd_valid, err, err_count);
    end
    rst = 1'b0;
    compared++;
    if (s_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready_low got=%0b required=0", s_ready); end
    cycle();
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready_rise got=%0b required=1", s_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(4, 1, 4);
    compared++;
    if (frame_valid !== 1'b1 || frame_num !== 16'd1) begin
      mismatched++; $display("FAIL basic_frame fv=%0b num=%0d required fv=1 num=1", frame_valid, frame_num);
    end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 2'(i);
      cycle();
      compared++;
      if (rd_valid !== 1'b1 || rd_re !== 36'(1 + i) || rd_im !== -36'(1 + i)) begin
        mismatched++;
        $display("FAIL basic_read%0d v=%0b re=%0h im=%0h required v=1 re=%0h im=%0h",
                 i, rd_valid, rd_re, rd_im, 36'(1 + i), -36'(1 + i));
      end
    end
    rd_en = 1'b0;
    cycle();
    compared++;
    if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL basic_rd_valid_drop got=%0b required=0", rd_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    send_frame(4, 1, 4);
    send_frame(4, 11, 4);
    compared++;
    if (s_ready !== 1'b0 || frame_num !== 16'd2) begin
      mismatched++; $display("FAIL stall_after2 ready=%0b num=%0d required ready=0 num=2", s_ready, frame_num);
    end
    s_valid = 1'b1; s_revis = 36'd21; s_imvis = -36'd21; s_last = 1'b0;
    cycle(); cycle(); cycle();
    compared++;
    if (s_ready !== 1'b0 || frame_num !== 16'd2) begin
      mismatched++; $display("FAIL stall_hold ready=%0b num=%0d required ready=0 num=2", s_ready, frame_num);
    end
    s_valid = 1'b0;
    rd_done = 1'b1;
    cycle();
    rd_done = 1'b0;
    compared++;
    if (s_ready !== 1'b1 || frame_valid !== 1'b1) begin
      mismatched++; $display("FAIL stall_release ready=%0b fv=%0b required ready=1 fv=1", s_ready, frame_valid);
    end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 2'(i);
      cycle();
      compared++;
      if (rd_re !== 36'(11 + i) || rd_im !== -36'(11 + i)) begin
        mismatched++; $display("FAIL stall_read_f2_%0d re=%0h required re=%0h", i, rd_re, 36'(11 + i));
      end
    end
    rd_en = 1'b0;
    send_frame(4, 21, 4);
    compared++;
    if (frame_num !== 16'd3 || s_ready !== 1'b0) begin
      mismatched++; $display("FAIL stall_f3 num=%0d ready=%0b required num=3 ready=0", frame_num, s_ready);
    end
    rd_done = 1'b1;
    cycle();
    rd_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 2'(i);
      cycle();
      compared++;
      if (frame_valid !== 1'b1 || rd_re !== 36'(21 + i) || rd_im !== -36'(21 + i)) begin
        mismatched++;
        $display("FAIL stall_read_f3_%0d fv=%0b re=%0h required fv=1 re=%0h", i, frame_valid, rd_re, 36'(21 + i));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_short();
    do_reset();
    send_frame(2, 1, 2);
    compared++;
    if (err !== 1'b1 || err_count !== 8'd1 || frame_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL short_err err=%0b cnt=%0d fv=%0b required err=1 cnt=1 fv=0", err, err_count, frame_valid);
    end
    cycle();
    compared++;
    if (err !== 1'b0) begin mismatched++; $display("FAIL short_err_pulse got=%0b required=0", err); end
    send_frame(4, 5, 4);
    rd_en = 1'b1; rd_addr = 2'd0;
    cycle();
    rd_en = 1'b0;
    compared++;
    if (frame_valid !== 1'b1 || frame_num !== 16'd1 || rd_re !== 36'd5) begin
      mismatched++;
      $display("FAIL short_next fv=%0b num=%0d re=%0h required fv=1 num=1 re=5", frame_valid, frame_num, rd_re);
    end
  endtask

  task automatic test_long();
    do_reset();
    send_frame(4, 1, 0);
    compared++;
    if (err !== 1'b1 || err_count !== 8'd1) begin
      mismatched++; $display("FAIL long_err err=%0b cnt=%0d required err=1 cnt=1", err, err_count);
    end
    send_frame(2, 5, 2);
    compared++;
    if (err !== 1'b0 || err_count !== 8'd1 || frame_valid !== 1'b0 || s_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL long_discard err=%0b cnt=%0d fv=%0b ready=%0b required 0/1/0/1", err, err_count, frame_valid, s_ready);
    end
    send_frame(4, 31, 4);
    for (int i = 0; i < 4; i += 3) begin
      rd_en = 1'b1; rd_addr = 2'(i);
      cycle();
      compared++;
      if (frame_num !== 16'd1 || rd_re !== 36'(31 + i) || rd_im !== -36'(31 + i)) begin
        mismatched++; $display("FAIL long_next%0d num=%0d re=%0h required num=1 re=%0h", i, frame_num, rd_re, 36'(31 + i));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(4, 1, 4);
    send_frame(3, 11, 0);
    s_valid = 1'b1; s_revis = 36'd14; s_imvis = -36'd14; s_last = 1'b1; rd_done = 1'b1;
    compared++;
    if (s_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_before got=%0b required=1", s_ready); end
    cycle();
    s_valid = 1'b0; s_last = 1'b0; rd_done = 1'b0;
    compared++;
    if (s_ready !== 1'b1 || frame_valid !== 1'b1 || frame_num !== 16'd2) begin
      mismatched++;
      $display("FAIL b2b_after ready=%0b fv=%0b num=%0d required ready=1 fv=1 num=2", s_ready, frame_valid, frame_num);
    end
    for (int i = 0; i < 4; i += 3) begin
      rd_en = 1'b1; rd_addr = 2'(i);
      cycle();
      compared++;
      if (rd_re !== 36'(11 + i) || rd_im !== -36'(11 + i) || s_ready !== 1'b1) begin
        mismatched++; $display("FAIL b2b_read%0d re=%0h ready=%0b required re=%0h ready=1", i, rd_re, s_ready, 36'(11 + i));
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(4, 1, 4);
    rd_en = 1'b1; rd_addr = 2'd0;
    send_frame(2, 7, 0);
    rst = 1'b1;
    #1;
    compared++;
    if ({s_ready, frame_valid, frame_num, rd_valid, rd_re, rd_im, err, err_count} !== '0) begin
      mismatched++;
      $display("FAIL midreset_outputs ready=%0b fv=%0b num=%0d rv=%0b re=%0h required all 0",
               s_ready, frame_valid, frame_num, rd_valid, rd_re);
    end
    rd_en = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    send_frame(4, 41, 4);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; rd_addr = 2'(i);
      cycle();
      compared++;
      if (frame_num !== 16'd1 || rd_re !== 36'(41 + i) || rd_im !== -36'(41 + i)) begin
        mismatched++; $display("FAIL midreset_read%0d num=%0d re=%0h required num=1 re=%0h", i, frame_num, rd_re, 36'(41 + i));
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_short();
    test_long();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
